// File: rtl/calc_seq.sv
// rtl/calc_seq.sv - iterated six-control ALU sequencer with command/result handshakes

module calc_alu (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out
);
    logic [15:0] x_z, x_n, y_z, y_n, r;

    always_comb begin
        x_z = zx ? 16'h0000 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? 16'h0000 : y;
        y_n = ny ? ~y_z : y_z;
        r   = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~r : r;
    end
endmodule

module calc_seq #(
    parameter int ITER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_x,
    input  logic [15:0]       cmd_y,
    input  logic [5:0]        cmd_ctrl,
    input  logic [ITER_W-1:0] cmd_iter,
    input  logic              abort,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_o,
    output logic              res_zr,
    output logic              res_ng,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [15:0]       acc;
    logic [15:0]       y_q;
    logic [5:0]        ctrl_q;
    logic [ITER_W-1:0] iter_q;
    // One bit wider than iter so an all-ones iter count never wraps before the compare.
    logic [ITER_W:0]   pass_cnt;
    logic [15:0]       alu_out;
    logic              accept;
    logic              last_pass;

    calc_alu u_alu (
        .x   (acc),
        .y   (y_q),
        .zx  (ctrl_q[5]),
        .nx  (ctrl_q[4]),
        .zy  (ctrl_q[3]),
        .ny  (ctrl_q[2]),
        .f   (ctrl_q[1]),
        .no  (ctrl_q[0]),
        .out (alu_out)
    );

    assign cmd_ready = (state_q == IDLE) && !abort;
    assign accept    = cmd_valid && cmd_ready;
    assign last_pass = (pass_cnt == {1'b0, iter_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_pass) begin
                    state_d = DONE;
                end
            end
            DONE: if (abort || res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= 16'h0000;
            y_q      <= 16'h0000;
            ctrl_q   <= 6'b000000;
            iter_q   <= '0;
            pass_cnt <= '0;
        end else if (accept) begin
            acc      <= cmd_x;
            y_q      <= cmd_y;
            ctrl_q   <= cmd_ctrl;
            iter_q   <= cmd_iter;
            pass_cnt <= '0;
        end else if (state_q == RUN && !abort) begin
            acc      <= alu_out;
            pass_cnt <= pass_cnt + (ITER_W+1)'(1);
        end
    end

    // Flags come from the registered accumulator so they hold with res_o under backpressure.
    assign res_valid = (state_q == DONE);
    assign res_o     = acc;
    assign res_zr    = (acc == 16'h0000);
    assign res_ng    = acc[15];
    assign busy      = (state_q != IDLE);
endmodule

// File: doc/calc_seq.md
CALC_SEQ -- requirements
Module: calc_seq

Interface
REQ-001 Parameter ITER_W, default 4, sets the width of cmd_iter; the maximum pass count is 2^ITER_W.
REQ-002 Port clk, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port cmd_valid, input, 1 bit: a command is present.
REQ-005 Port cmd_ready, output, 1 bit: the block accepts a command this cycle.
REQ-006 Port cmd_x, input, 16 bits: initial X operand.
REQ-007 Port cmd_y, input, 16 bits: Y operand, constant for all passes.
REQ-008 Port cmd_ctrl, input, 6 bits: ALU controls, [5]=zx [4]=nx [3]=zy [2]=ny [1]=f [0]=no.
REQ-009 Port cmd_iter, input, ITER_W bits: pass count minus 1.
REQ-010 Port abort, input, 1 bit: synchronous cancel of the operation in flight.
REQ-011 Port res_valid, output, 1 bit: a result is present.
REQ-012 Port res_ready, input, 1 bit: the consumer takes the result.
REQ-013 Port res_o, output, 16 bits: final result.
REQ-014 Port res_zr, output, 1 bit: high when res_o==0.
REQ-015 Port res_ng, output, 1 bit: equals res_o[15].
REQ-016 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The block shall instantiate the team's existing 16-bit six-control ALU. The controls give zero/negate on X, zero/negate on Y, f=1 selects add (f=0 selects AND), and no negates the output.
REQ-018 FSM states: IDLE, RUN, DONE.
REQ-019 cmd_ready = (state==IDLE) && !abort.
REQ-020 A command is accepted on the edge where cmd_valid && cmd_ready. On that edge the block latches y, ctrl and iter, loads acc <= cmd_x, clears the pass counter and goes to RUN.
REQ-021 RUN performs one ALU pass per cycle: ALU X=acc, Y=latched y, controls=latched ctrl. On each edge, acc <= ALU output and the pass counter increments.
REQ-022 After pass number latched iter+1 completes, the FSM goes to DONE on the same edge, with res_o=acc.
REQ-023 res_valid is high only in DONE. res_o, res_zr and res_ng hold stable while res_valid && !res_ready.
REQ-024 On the edge where res_valid && res_ready, the FSM goes DONE->IDLE. A new command can be accepted on the following edge at the earliest; commands do not overlap.
REQ-025 Latency: res_valid rises exactly iter+1 cycles after the accept edge.
REQ-026 Arithmetic is modulo 2^16. There is no carry or overflow output, and wrap-around is silent.
REQ-027 res_zr and res_ng are derived from the registered acc, never from the live ALU output.
REQ-028 abort in RUN or DONE forces IDLE on the next edge; res_valid drops and no result is delivered.
REQ-029 abort in IDLE has no effect other than holding cmd_ready low.
REQ-030 If abort and res_ready are both high in DONE, the FSM goes to IDLE. The handshake is treated as complete, so the result counts as consumed.
REQ-031 In IDLE, cmd_* inputs are ignored unless cmd_valid && cmd_ready.
REQ-032 In RUN and DONE, all cmd_* inputs are ignored.
REQ-033 cmd_iter all-ones gives 2^ITER_W passes; the pass counter shall not wrap before the terminal compare.

Reset
REQ-034 While rst_n=0, the state goes to IDLE immediately, regardless of clk.
REQ-035 Reset values: acc=0, pass counter=0, latched y/ctrl/iter=0.
REQ-036 Reset values of outputs: res_valid=0, busy=0, res_o=0, res_zr=1, res_ng=0.
REQ-037 cmd_ready=1 once rst_n=1, provided abort=0.
REQ-038 Reset asserted in RUN or DONE discards the operation, and no res_valid pulse follows.
REQ-039 Reset release is synchronised externally; the first accept edge is the first rising edge after release.

Verification
REQ-040 Single add: x=3, y=5, ctrl=000010, iter=0 -> res_o=0x0008, zr=0, ng=0, res_valid 1 cycle after accept.
REQ-041 Accumulate: x=3, y=5, ctrl=000010, iter=3 -> res_o=0x0017 (23), res_valid exactly 4 cycles after accept.
REQ-042 Subtract with flags: x=2, y=5, ctrl=010011 (x-y) -> res_o=0xFFFD, ng=1, zr=0.
REQ-043 Zero and wrap cases:
- AND: x=0x00F0, y=0x0F00, ctrl=000000 -> res_o=0, zr=1.
- Add: x=0xFFFF, y=1, ctrl=000010 -> res_o=0, zr=1.
REQ-044 Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_o stay stable and cmd_ready=0; raise res_ready -> IDLE and cmd_ready=1 on the next cycle.
REQ-045 abort pulsed in the 2nd RUN cycle of an iter=7 command -> IDLE on the next edge, no res_valid.
REQ-046 rst_n pulsed low mid-RUN -> busy=0 immediately, and the next command completes correctly.
